// File: rtl/hazard_control_unit.sv
// Pipeline hazard unit for the 5-stage RISC-V core.
// Raises load-use bubbles and bubbles for operands consumed in ID (ecall,
// and branches when resolved in ID). A small FSM freezes the whole pipeline
// for MEM_LATENCY cycles per data-memory access. Saturating counters track
// bubble and freeze cycles.
module hazard_control_unit #(
    parameter int REG_ADDR_W    = 5,
    parameter int MEM_LATENCY   = 0,
    parameter int BRANCH_IN_ID  = 0,
    parameter int MEM_TO_ID_FWD = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_is_ecall,
    input  logic                  id_is_branch,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic                  mem_access,
    input  logic                  perf_clear,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  ID_nop_signal,
    output logic                  pipe_freeze,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      freeze_count
);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    localparam bit HAS_LAT = (MEM_LATENCY > 0);
    localparam bit BR_ID   = (BRANCH_IN_ID != 0);
    localparam bit NO_FWD  = (MEM_TO_ID_FWD == 0);
    // cnt only ever holds MEM_LATENCY-1 down to 1
    localparam int CB = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CB-1:0]    CNT_LOAD = CB'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

    state_t        state;
    logic [CB-1:0] cnt;
    logic          rs1_used, rs2_used, rs1_live, rs2_live;
    logic          match_ex, match_mem, id_consumer, hazard, start;

    // Decode which source operands the ID instruction actually reads
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode)
            OP_ARITH, OP_STORE, OP_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_ARITH_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: rs1_used = 1'b1;
            default: ;
        endcase
        if (id_is_ecall) rs1_used = 1'b1;
    end

    // x0 is hard-wired zero and never carries a dependency
    assign rs1_live = rs1_used & (id_rs1 != '0);
    assign rs2_live = rs2_used & (id_rs2 != '0);

    assign match_ex  = ex_reg_write &
                       ((rs1_live & (id_rs1 == ex_rd)) | (rs2_live & (id_rs2 == ex_rd)));
    assign match_mem = mem_reg_write &
                       ((rs1_live & (id_rs1 == mem_rd)) | (rs2_live & (id_rs2 == mem_rd)));

    assign id_consumer = id_is_ecall | (BR_ID & id_is_branch);

    // A load in MEM cannot be forwarded to ID; an ALU result only if the path exists
    assign hazard = (ex_mem_read & match_ex) |
                    (id_consumer & (match_ex | (match_mem & mem_mem_read) | (match_mem & NO_FWD)));

    // A new access starts its freeze in the same cycle it reaches MEM
    assign start       = HAS_LAT & (state == S_IDLE) & mem_access;
    assign pipe_freeze = reset & (start | (state == S_WAIT));

    // Freeze overrides the bubble; the hazard is re-evaluated after release
    assign ID_nop_signal = ~pipe_freeze & hazard;
    assign PC_write      = ~pipe_freeze & ~hazard;
    assign IF_ID_write   = ~pipe_freeze & ~hazard;

    // Freeze FSM: IDLE counts the first cycle, WAIT the rest, RELEASE lets the access leave
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cnt   <= CNT_LOAD;
                    state <= (MEM_LATENCY == 1) ? S_RELEASE : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CB'(1)) state <= S_RELEASE;
                end
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Saturating bubble counter; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                      stall_count <= '0;
        else if (perf_clear)                             stall_count <= '0;
        else if (ID_nop_signal && stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
    end

    // Saturating freeze counter; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                       freeze_count <= '0;
        else if (perf_clear)                              freeze_count <= '0;
        else if (pipe_freeze && freeze_count != CNT_MAX) freeze_count <= freeze_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: five instances with different
// parameter sets share the ID/EX/MEM stimulus; each freezing instance has
// its own mem_access so freeze sequences can be driven independently.
module tb_hazard_control_unit;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic id_is_ecall, id_is_branch, ex_reg_write, ex_mem_read;
    logic mem_reg_write, mem_mem_read, perf_clear;
    logic ma_c, ma_d, ma_e;

    logic pc_a, ifid_a, nop_a, frz_a; logic [15:0] sc_a, fc_a;
    logic pc_b, ifid_b, nop_b, frz_b; logic [15:0] sc_b, fc_b;
    logic pc_c, ifid_c, nop_c, frz_c; logic [15:0] sc_c, fc_c;
    logic pc_d, ifid_d, nop_d, frz_d; logic [15:0] sc_d, fc_d;
    logic pc_e, ifid_e, nop_e, frz_e; logic [3:0]  sc_e, fc_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: defaults. B: branch in ID, no MEM->ID forwarding.
    hazard_control_unit #(.MEM_LATENCY(0), .BRANCH_IN_ID(0), .MEM_TO_ID_FWD(1)) u_a (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_ecall(id_is_ecall), .id_is_branch(id_is_branch), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_access(ma_c),
        .perf_clear(perf_clear), .PC_write(pc_a), .IF_ID_write(ifid_a),
        .ID_nop_signal(nop_a), .pipe_freeze(frz_a), .stall_count(sc_a), .freeze_count(fc_a));

    hazard_control_unit #(.MEM_LATENCY(0), .BRANCH_IN_ID(1), .MEM_TO_ID_FWD(0)) u_b (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_ecall(id_is_ecall), .id_is_branch(id_is_branch), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_access(ma_c),
        .perf_clear(perf_clear), .PC_write(pc_b), .IF_ID_write(ifid_b),
        .ID_nop_signal(nop_b), .pipe_freeze(frz_b), .stall_count(sc_b), .freeze_count(fc_b));

    hazard_control_unit #(.MEM_LATENCY(3)) u_c (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_ecall(id_is_ecall), .id_is_branch(id_is_branch), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_access(ma_c),
        .perf_clear(perf_clear), .PC_write(pc_c), .IF_ID_write(ifid_c),
        .ID_nop_signal(nop_c), .pipe_freeze(frz_c), .stall_count(sc_c), .freeze_count(fc_c));

    hazard_control_unit #(.MEM_LATENCY(2)) u_d (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_ecall(id_is_ecall), .id_is_branch(id_is_branch), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_access(ma_d),
        .perf_clear(perf_clear), .PC_write(pc_d), .IF_ID_write(ifid_d),
        .ID_nop_signal(nop_d), .pipe_freeze(frz_d), .stall_count(sc_d), .freeze_count(fc_d));

    hazard_control_unit #(.MEM_LATENCY(4), .CNT_W(4)) u_e (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_is_ecall(id_is_ecall), .id_is_branch(id_is_branch), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_access(ma_e),
        .perf_clear(perf_clear), .PC_write(pc_e), .IF_ID_write(ifid_e),
        .ID_nop_signal(nop_e), .pipe_freeze(frz_e), .stall_count(sc_e), .freeze_count(fc_e));

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ecall;
        logic       br;
        logic [4:0] exrd;
        logic       exrw;
        logic       exmr;
        logic [4:0] memrd;
        logic       memrw;
        logic       memmr;
        logic       exp_a;
        logic       exp_b;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        id_opcode = v.op; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_is_ecall = v.ecall; id_is_branch = v.br;
        ex_rd = v.exrd; ex_reg_write = v.exrw; ex_mem_read = v.exmr;
        mem_rd = v.memrd; mem_reg_write = v.memrw; mem_mem_read = v.memmr;
    endtask

    task automatic idle();
        id_opcode = OP_ADDI; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_is_ecall = 1'b0; id_is_branch = 1'b0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    endtask

    initial begin
        int sum_a, sum_b;
        logic [3:0] pat_d;
        //           op       rs1    rs2    ecl   br    exrd   exrw  exmr  memrd  memrw memmr  A     B
        tbl[0]  = '{OP_ADD,  5'd5,  5'd7,  1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1}; // load-use
        tbl[1]  = '{OP_ADD,  5'd0,  5'd7,  1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0}; // x0
        tbl[2]  = '{OP_SYS,  5'd17, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1}; // ecall, MEM addi
        tbl[3]  = '{OP_SYS,  5'd17, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd17, 1'b1, 1'b1, 1'b1, 1'b1}; // ecall, MEM lw
        tbl[4]  = '{OP_BEQ,  5'd3,  5'd4,  1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1}; // beq, EX alu
        tbl[5]  = '{OP_ADD,  5'd2,  5'd3,  1'b0, 1'b0, 5'd2,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0}; // EX alu, add
        tbl[6]  = '{OP_ADDI, 5'd5,  5'd7,  1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0}; // rs2 unused
        tbl[7]  = '{OP_SW,   5'd1,  5'd9,  1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1}; // store rs2
        tbl[8]  = '{OP_SYS,  5'd17, 5'd0,  1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1}; // ecall, EX alu
        tbl[9]  = '{OP_LW,   5'd4,  5'd0,  1'b0, 1'b0, 5'd4,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0}; // no reg write
        tbl[10] = '{OP_LUI,  5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0}; // lui no rs
        tbl[11] = '{OP_JALR, 5'd8,  5'd0,  1'b0, 1'b0, 5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1}; // jalr
        tbl[12] = '{OP_BEQ,  5'd3,  5'd4,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1}; // beq, MEM lw
        tbl[13] = '{OP_BEQ,  5'd3,  5'd4,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1}; // beq, MEM alu

        // Reset state: outputs follow inputs, freeze held off even with mem_access
        reset = 1'b0; perf_clear = 1'b0; ma_c = 1'b1; ma_d = 1'b0; ma_e = 1'b0;
        idle();
        #3;
        check("rst_pc_write", pc_a, 1);
        check("rst_ifid_write", ifid_a, 1);
        check("rst_nop", nop_a, 0);
        check("rst_freeze_c", frz_c, 0);
        check("rst_stall_cnt", sc_a, 0);
        check("rst_freeze_cnt", fc_c, 0);
        ma_c = 1'b0;
        @(negedge clk) reset = 1'b1;

        // Table of combinational hazard cases
        sum_a = 0; sum_b = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            apply(tbl[i]);
            #1;
            check($sformatf("v%0d_nop_a", i), nop_a, tbl[i].exp_a);
            check($sformatf("v%0d_pc_a", i), pc_a, !tbl[i].exp_a);
            check($sformatf("v%0d_ifid_a", i), ifid_a, !tbl[i].exp_a);
            check($sformatf("v%0d_nop_b", i), nop_b, tbl[i].exp_b);
            check($sformatf("v%0d_pc_b", i), pc_b, !tbl[i].exp_b);
            sum_a += int'(tbl[i].exp_a);
            sum_b += int'(tbl[i].exp_b);
        end
        @(posedge clk); #1; idle(); #1;
        check("tbl_stall_cnt_a", sc_a, sum_a);
        check("tbl_stall_cnt_b", sc_b, sum_b);

        // Clear counters
        perf_clear = 1'b1;
        @(posedge clk); #1; perf_clear = 1'b0; #1;
        check("clear_stall_cnt", sc_a, 0);

        // LAT=3 freeze with concurrent load-use; access stays in MEM through RELEASE
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            apply(tbl[0]);
            ma_c = (k < 4);
            #1;
            check($sformatf("c%0d_freeze", k), frz_c, (k < 3));
            check($sformatf("c%0d_nop", k), nop_c, (k >= 3));
            check($sformatf("c%0d_pc", k), pc_c, 0);
            check($sformatf("c%0d_freeze_a", k), frz_a, 0);
        end
        @(posedge clk); #1; idle(); #1;
        check("c_freeze_cnt", fc_c, 3);
        check("c_stall_cnt", sc_c, 3);
        check("a_freeze_cnt", fc_a, 0);

        // Back-to-back stores, LAT=2: 1,1,0,1,1,0
        pat_d = 4'd0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            ma_d = (k < 6);
            #1;
            check($sformatf("d%0d_freeze", k), frz_d, (k == 0 || k == 1 || k == 3 || k == 4));
            check($sformatf("d%0d_nop", k), nop_d, 0);
            pat_d = pat_d + 4'(frz_d);
        end
        check("d_freeze_cycles", pat_d, 4);
        @(posedge clk); #2;
        check("d_freeze_cnt", fc_d, 4);

        // LAT=4: reset asserted in cycle 2 of the freeze
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1; ma_e = 1'b1; #1;
            check($sformatf("e%0d_pre_freeze", k), frz_e, 1);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("e_rst_freeze", frz_e, 0);
        check("e_rst_freeze_cnt", fc_e, 0);
        check("e_rst_pc", pc_e, 1);
        ma_e = 1'b0;
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1; ma_e = 1'b1; #1;
            check($sformatf("e%0d_freeze", k), frz_e, (k < 4));
        end
        @(posedge clk); #1; ma_e = 1'b0; #1;
        check("e_freeze_cnt", fc_e, 4);

        // Saturation: 20 bubble cycles into a 4-bit counter
        perf_clear = 1'b1;
        @(posedge clk); #1; perf_clear = 1'b0;
        apply(tbl[0]);
        repeat (20) @(posedge clk);
        #1; idle(); #1;
        check("e_stall_sat", sc_e, 15);
        check("a_stall_nosat", sc_a, 20);

        // Clear wins over a simultaneous increment
        @(posedge clk); #1; apply(tbl[0]); perf_clear = 1'b1;
        @(posedge clk); #1; perf_clear = 1'b0; idle(); #1;
        check("clear_priority_a", sc_a, 0);
        check("clear_priority_e", sc_e, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised pipeline hazard unit for the 5-stage RISC-V core; it generalises the single-cycle load-use/ecall stall logic. It detects load-use hazards and hazards on operands consumed in ID (ecall, and branches when BRANCH_IN_ID=1), with optional MEM-to-ID forwarding. It adds a counter-driven freeze FSM that models fixed multi-cycle data-memory latency, and saturating performance counters for bubbles and freezes.

Parameters:
REG_ADDR_W, 5, register-index width
MEM_LATENCY, 0, data-memory access latency in cycles; 0 = single-cycle memory, freeze logic inert
BRANCH_IN_ID, 0, 1 = branch comparison resolved in ID; branches treated like ecall for hazard checks
MEM_TO_ID_FWD, 1, 1 = ALU results in MEM are forwarded to ID comparators; 0 = no such path
CNT_W, 16, performance counter width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
id_opcode  in  7  opcode of the instruction in ID
id_rs1  in  REG_ADDR_W  ID source 1; decode supplies x17 here for ECALL
id_rs2  in  REG_ADDR_W  ID source 2
id_is_ecall  in  1  ID holds ECALL
id_is_branch  in  1  ID holds conditional branch
ex_rd  in  REG_ADDR_W  destination register in EX
ex_reg_write  in  1  EX instruction writes rd
ex_mem_read  in  1  EX instruction is a load
mem_rd  in  REG_ADDR_W  destination register in MEM
mem_reg_write  in  1  MEM instruction writes rd
mem_mem_read  in  1  MEM instruction is a load
mem_access  in  1  MEM holds a load or store
perf_clear  in  1  synchronous clear of both counters
PC_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID latch enable
ID_nop_signal  out  1  inject bubble into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB (full-pipeline stall)
stall_count  out  CNT_W  cycles with ID_nop_signal=1
freeze_count  out  CNT_W  cycles with pipe_freeze=1

Behaviour:
- Operand use: rs1 is used for ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JALR, ECALL. rs2 is used for ARITHMETIC, STORE, BRANCH. Index 0 never creates a hazard.
- match_ex = ex_reg_write & (used rs == ex_rd). match_mem = mem_reg_write & (used rs == mem_rd).
- Load-use: ex_mem_read & match_ex -> bubble.
- ID-consumer = id_is_ecall | (BRANCH_IN_ID & id_is_branch). A bubble is raised if ID-consumer and any of:
  - match_ex;
  - match_mem & mem_mem_read;
  - match_mem & MEM_TO_ID_FWD==0.
- Bubble outputs: PC_write=0, IF_ID_write=0, ID_nop_signal=1. With no hazard and no freeze: 1,1,0.
- Freeze FSM, states IDLE, WAIT, RELEASE, with internal down-counter cnt:
  - IDLE: if mem_access and MEM_LATENCY>0, pipe_freeze=1 combinationally this cycle and cnt<=MEM_LATENCY-1. Next state is RELEASE if MEM_LATENCY==1, else WAIT.
  - WAIT: pipe_freeze=1; cnt<=cnt-1; next state is RELEASE when cnt==1.
  - RELEASE: pipe_freeze=0; mem_access ignored (same instruction leaving MEM); next state is IDLE.
  - Total freeze per access is exactly MEM_LATENCY cycles. Back-to-back memory instructions refreeze from IDLE one cycle after RELEASE.
- Priority: pipe_freeze=1 forces PC_write=0, IF_ID_write=0, ID_nop_signal=0. The freeze overrides the bubble; hazard detection re-evaluates after release.
- Counters: each saturates at all-ones. stall_count increments on each cycle with ID_nop_signal=1; freeze_count on each cycle with pipe_freeze=1. perf_clear has priority over increment.
- Reset (reset=0, asynchronous):
  - State IDLE, cnt=0, counters=0, pipe_freeze=0 immediately, including mid-freeze.
  - Combinational outputs follow the inputs; with no hazard: PC_write=1, IF_ID_write=1, ID_nop_signal=0.
- MEM_LATENCY=0: FSM stays in IDLE; pipe_freeze and freeze_count remain 0.

Test Plan:
- Load-use: EX lw x5 (ex_mem_read=1, ex_rd=5); ID add x6,x5,x7 -> one cycle PC_write=0, IF_ID_write=0, ID_nop_signal=1; stall_count=1. Same with ID rs=x0 -> no stall.
- Ecall distance 2: ID ECALL (rs1=17); MEM addi x17 (mem_mem_read=0) -> no stall with MEM_TO_ID_FWD=1; bubble with MEM_TO_ID_FWD=0. MEM lw x17 -> bubble under both settings.
- Branch in ID: BRANCH_IN_ID=1, ID beq x3,x4; EX writes x4 -> bubble. With BRANCH_IN_ID=0 and the same stimulus -> no bubble.
- Freeze, MEM_LATENCY=3: mem_access=1 for one instruction -> pipe_freeze high exactly 3 cycles, then low in RELEASE; freeze_count=3. Concurrent load-use during freeze -> ID_nop_signal=0 until release, then 1.
- Back-to-back: two stores consecutive in MEM, MEM_LATENCY=2 -> freeze pattern 1,1,0,1,1,0; freeze_count=4.
- Reset mid-WAIT: assert reset=0 in cycle 2 of a MEM_LATENCY=4 freeze -> pipe_freeze drops immediately and counters=0. After release, a new mem_access freezes for a full 4 cycles. Saturation: preload near max by long stall -> stall_count holds at 2^CNT_W-1.
